// File: rtl/pwm_key_pkg.sv
// Shared types and constants for the PS/2-driven PWM key sequencer.
package pwm_key_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_BREAK,
        DEC_EXT
    } dec_state_t;

    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_Q     = 8'h15;
    localparam logic [7:0] KEY_H     = 8'h33;
    localparam logic [7:0] KEY_X     = 8'h22;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

    localparam int DUTY_F     = 41;
    localparam int DUTY_Q     = 51;
    localparam int DUTY_H     = 61;
    localparam int DUTY_X     = 81;
    localparam int DUTY_SPACE = 0;

    function automatic logic is_mapped(input logic [7:0] code);
        return (code == KEY_F) || (code == KEY_Q) || (code == KEY_H) ||
               (code == KEY_X) || (code == KEY_SPACE);
    endfunction

    function automatic int key_duty(input logic [7:0] code);
        int value;
        value = DUTY_SPACE;
        case (code)
            KEY_F:   value = DUTY_F;
            KEY_Q:   value = DUTY_Q;
            KEY_H:   value = DUTY_H;
            KEY_X:   value = DUTY_X;
            default: value = DUTY_SPACE;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/pwm_key_sequencer_decoder.sv
// PS/2 set-2 make-code decoder: drops break and extended sequences and
// strobes load with the mapped duty for a plain make code.
module ps2_make_decoder
    import pwm_key_pkg::*;
#(
    parameter int DUTY_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_valid,
    input  logic [7:0]        scancode,
    output logic              load,
    output logic [DUTY_W-1:0] value
);

    dec_state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DEC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Extended codes are never mapped, so the byte after 0xE0 is swallowed.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        value      = DUTY_W'(key_duty(scancode));
        if (scan_valid) begin
            case (state)
                DEC_IDLE: begin
                    if (scancode == PFX_BREAK) begin
                        state_next = DEC_BREAK;
                    end else if (scancode == PFX_EXT) begin
                        state_next = DEC_EXT;
                    end else begin
                        load = is_mapped(scancode);
                    end
                end
                DEC_BREAK: begin
                    state_next = DEC_IDLE;
                end
                DEC_EXT: begin
                    if (scancode == PFX_BREAK) begin
                        state_next = DEC_BREAK;
                    end else begin
                        state_next = DEC_IDLE;
                    end
                end
                default: begin
                    state_next = DEC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_key_sequencer.sv
// PWM generator whose duty follows keyboard-selected targets, updated only at
// period boundaries. Define PWM_KEY_RAMP_EN to slew duty by STEP per period.
module pwm_key_sequencer
    import pwm_key_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int PERIOD  = 800,
    parameter int DUTY_W  = 10,
    parameter int STEP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_valid,
    input  logic [7:0]        scancode,
    output logic              pwm,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] target,
    output logic              busy,
    output logic              period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]     presc;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] load_value;
    logic              load;
    logic              tick;
    logic              boundary;

    ps2_make_decoder #(
        .DUTY_W (DUTY_W)
    ) u_decoder (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scancode   (scancode),
        .load       (load),
        .value      (load_value)
    );

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign boundary = tick && (cnt == DUTY_W'(PERIOD - 1));
    assign busy     = (duty != target);

`ifdef PWM_KEY_RAMP_EN
    localparam logic [DUTY_W-1:0] STEP_W = DUTY_W'(STEP);

    // Clamp the last step so duty lands exactly on target.
    always_comb begin
        duty_next = duty;
        if (target > duty) begin
            duty_next = ((target - duty) > STEP_W) ? duty + STEP_W : target;
        end else if (target < duty) begin
            duty_next = ((duty - target) > STEP_W) ? duty - STEP_W : target;
        end
    end
`else
    always_comb begin
        duty_next = target;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= (cnt == DUTY_W'(PERIOD - 1)) ? '0 : cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A target loaded on the boundary cycle is only seen at the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty         <= '0;
            target       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (boundary) begin
                duty <= duty_next;
            end
            if (load) begin
                target <= load_value;
            end
            pwm          <= (cnt < duty);
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_key_sequencer.sv
// Self-checking bench for pwm_key_sequencer: decode table, ramp/immediate
// duty tracking, boundary collision, random keys and mid-ramp reset.
module tb_pwm_key_sequencer;

    localparam int CLK_DIV = 1;
    localparam int PERIOD  = 800;
    localparam int DUTY_W  = 10;
    localparam int STEP    = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              scan_valid;
    logic [7:0]        scancode;
    logic              pwm;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] target;
    logic              busy;
    logic              period_start;

    int errors = 0;
    int checks = 0;

    int edges;
    int mDuty;
    int mTarget;
    bit mPwm;
    bit mPs;
    bit skipNext;
    bit extPfx;

    typedef struct {
        logic       v;
        logic [7:0] code;
        int         expTarget;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] pool[10];

    always #5 clk = ~clk;

    pwm_key_sequencer #(
        .CLK_DIV (CLK_DIV),
        .PERIOD  (PERIOD),
        .DUTY_W  (DUTY_W),
        .STEP    (STEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_valid   (scan_valid),
        .scancode     (scancode),
        .pwm          (pwm),
        .duty         (duty),
        .target       (target),
        .busy         (busy),
        .period_start (period_start)
    );

    // Reference: duty moves toward target once per period boundary.
    function automatic int approach(input int d, input int t);
`ifdef PWM_KEY_RAMP_EN
        if (t > d) return d + (((t - d) < STEP) ? (t - d) : STEP);
        if (t < d) return d - (((d - t) < STEP) ? (d - t) : STEP);
        return d;
`else
        return t + 0 * d;
`endif
    endfunction

    function automatic int keyDuty(input logic [7:0] code);
        case (code)
            8'h2B:   return 41;
            8'h15:   return 51;
            8'h33:   return 61;
            8'h22:   return 81;
            8'h29:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic bit nextIsBoundary();
        return (((edges + 1) % CLK_DIV) == 0) && (((edges / CLK_DIV) % PERIOD) == PERIOD - 1);
    endfunction

    task automatic modelReset();
        edges = 0; mDuty = 0; mTarget = 0; mPwm = 0; mPs = 0;
        skipNext = 0; extPfx = 0;
    endtask

    task automatic modelEdge(input logic v, input logic [7:0] code);
        int pos;
        int kd;
        bit bnd;
        pos  = (edges / CLK_DIV) % PERIOD;
        bnd  = nextIsBoundary();
        mPwm = (pos < mDuty);
        mPs  = bnd;
        if (bnd) mDuty = approach(mDuty, mTarget);
        if (v) begin
            if (skipNext) begin
                skipNext = 0;
            end else if (extPfx) begin
                extPfx   = 0;
                skipNext = (code == 8'hF0);
            end else if (code == 8'hF0) begin
                skipNext = 1;
            end else if (code == 8'hE0) begin
                extPfx = 1;
            end else begin
                kd = keyDuty(code);
                if (kd >= 0) mTarget = kd;
            end
        end
        edges++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic applyStimulus(input logic v, input logic [7:0] code);
        scan_valid = v;
        scancode   = code;
        @(posedge clk);
        modelEdge(v, code);
        @(negedge clk);
        scan_valid = 1'b0;
        checkOutput("cycle {pwm,duty,target,busy,pstart}",
                    32'({pwm, duty, target, busy, period_start}),
                    32'({mPwm, DUTY_W'(mDuty), DUTY_W'(mTarget), (mDuty != mTarget), mPs}));
    endtask

    task automatic doReset();
        reset      = 1'b1;
        scan_valid = 1'b0;
        scancode   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset pwm", 32'(pwm), 32'd0);
        checkOutput("reset duty", 32'(duty), 32'd0);
        checkOutput("reset target", 32'(target), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic runToBoundary();
        while (!nextIsBoundary()) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
    endtask

    task automatic runUntilDuty(input int want, input int budget, input string name);
        int n;
        n = 0;
        while (mDuty < want && n < budget) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput(name, 32'(duty >= DUTY_W'(want)), 32'd1);
    endtask

    task automatic measurePwm(input int expHigh, input string name);
        int n;
        int highs;
        n = 0;
        while (!period_start && n < 2 * PERIOD) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput({name, " period_start seen"}, 32'(period_start), 32'd1);
        highs = int'(pwm);
        repeat (PERIOD - 1) begin
            applyStimulus(1'b0, 8'h00);
            highs += int'(pwm);
        end
        checkOutput(name, 32'(highs), 32'(expHigh));
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int highs;
        int d0;

        vecs[0]  = '{1'b1, 8'h2B, 41};
        vecs[1]  = '{1'b0, 8'h22, 41};
        vecs[2]  = '{1'b1, 8'hF0, 41};
        vecs[3]  = '{1'b1, 8'h22, 41};
        vecs[4]  = '{1'b1, 8'hE0, 41};
        vecs[5]  = '{1'b1, 8'h15, 41};
        vecs[6]  = '{1'b1, 8'h33, 61};
        vecs[7]  = '{1'b1, 8'h5A, 61};
        vecs[8]  = '{1'b1, 8'hE0, 61};
        vecs[9]  = '{1'b1, 8'hF0, 61};
        vecs[10] = '{1'b1, 8'h29, 61};
        vecs[11] = '{1'b1, 8'h29, 0};
        vecs[12] = '{1'b1, 8'hE0, 0};
        vecs[13] = '{1'b1, 8'h12, 0};
        vecs[14] = '{1'b1, 8'h2B, 41};
        pool = '{8'h2B, 8'h15, 8'h33, 8'h22, 8'h29, 8'hF0, 8'hE0, 8'h5A, 8'h1C, 8'h2B};

        modelReset();
        doReset();

        n = 0;
        while (!period_start && n < PERIOD + 100) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("first period_start latency", 32'(n), 32'(PERIOD));

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].v, vecs[i].code);
            checkOutput($sformatf("table target %0d", i), 32'(target), 32'(vecs[i].expTarget));
        end

        runUntilDuty(41, 45 * PERIOD, "ramp reaches 41");
        checkOutput("duty at 41", 32'(duty), 32'd41);
        checkOutput("busy clear at 41", 32'(busy), 32'd0);
        measurePwm(41, "pwm highs at 41");

        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h22);
        checkOutput("break filtered", 32'(target), 32'd41);
        applyStimulus(1'b1, 8'hE0);
        applyStimulus(1'b1, 8'h15);
        checkOutput("ext filtered", 32'(target), 32'd41);
        applyStimulus(1'b1, 8'h22);
        checkOutput("idle after ext", 32'(target), 32'd81);

        repeat (3) runToBoundary();
`ifdef PWM_KEY_RAMP_EN
        checkOutput("duty after 3 boundaries", 32'(duty), 32'd44);
        measurePwm(44, "pwm highs after 3 boundaries");
`else
        checkOutput("duty after 3 boundaries", 32'(duty), 32'd81);
        measurePwm(81, "pwm highs at 81");
`endif

        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h15);
        checkOutput("target 51", 32'(target), 32'd51);
        d0 = mDuty;
        while (!nextIsBoundary()) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h33);
`ifdef PWM_KEY_RAMP_EN
        checkOutput("collision duty", 32'(duty), 32'(d0 + 1));
`else
        checkOutput("collision duty", 32'(duty), 32'd51);
`endif
        checkOutput("collision target", 32'(target), 32'd61);
        runToBoundary();
`ifdef PWM_KEY_RAMP_EN
        checkOutput("duty after collision", 32'(duty), 32'(d0 + 2));
`else
        checkOutput("duty after collision", 32'(duty), 32'd61);
`endif

        repeat (3 * PERIOD) begin
            if ($urandom_range(0, 15) == 0)
                applyStimulus(1'b1, pool[$urandom_range(0, 9)]);
            else
                applyStimulus(1'b0, 8'h00);
        end

        doReset();
        applyStimulus(1'b1, 8'h22);
        runUntilDuty(30, 35 * PERIOD, "ramp reaches 30");
        repeat (5) applyStimulus(1'b0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset pwm", 32'(pwm), 32'd0);
        checkOutput("async reset duty", 32'(duty), 32'd0);
        checkOutput("async reset target", 32'(target), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 8'h29);
        highs = 0;
        repeat (2 * PERIOD) begin
            applyStimulus(1'b0, 8'h00);
            highs += int'(pwm);
        end
        checkOutput("space keeps pwm low", 32'(highs), 32'd0);
        checkOutput("space keeps duty 0", 32'(duty), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
